fir_stream_seq: RTL
===================

# fir_stream_seq

Parametrised, streaming, time-multiplexed FIR filter for the synthetic filter family. Unlike the fixed 4-tap combinational filter, it keeps its own sample history, takes one sample per handshake, and evaluates all taps with a single multiplier-accumulator. Coefficients are static parameters. It sits between a valid/ready sample source and a valid/ready result sink.

## Interface
- `DATA_W`, default 16: unsigned input sample width.
- `TAPS`, default 4: number of taps, minimum 2.
- `COEF_W`, default 8: unsigned coefficient width.
- `COEFS`, default `{8'd4,8'd3,8'd2,8'd1}`: packed coefficients. `c[k] = COEFS[k*COEF_W +: COEF_W]`.
- `OUT_W`, default `DATA_W+COEF_W+$clog2(TAPS)`: result width. Must not be set smaller.
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `clear`, in, 1: synchronous history flush and abort.
- `in_data`, in, DATA_W: input sample.
- `in_valid`, in, 1: sample present.
- `in_ready`, out, 1: block can accept a sample.
- `out_data`, out, OUT_W: filter result.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: sink accepts the result.

## Operation
- Output: `y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k]`. All arithmetic is unsigned.
- Delay line: `d[0..TAPS-1]`, DATA_W each.
  - Samples older than the history are 0. History is zeroed on `rst` and on `clear`.
- Accumulator: OUT_W wide, no saturation. The OUT_W rule guarantees no overflow.
- State machine: IDLE -> MAC -> OUT -> IDLE.
  - IDLE: `in_ready=1`. On `in_valid`, the sample is accepted:
    - `d[0]<=in_data`, `d[k]<=d[k-1]`.
    - Tap index `k<=0`, `acc<=0`, go to MAC.
  - MAC: one tap per cycle, `acc<=acc+c[k]*d[k]`, `k<=k+1`.
    - On the cycle with `k==TAPS-1`, `out_data<=acc+c[k]*d[k]`, `out_valid<=1`, go to OUT.
  - OUT: `out_data` and `out_valid` are held stable until `out_ready` is sampled high. Then `out_valid<=0` and the FSM goes to IDLE.
- `in_ready` is exactly `state==IDLE`. No sample is accepted in MAC or OUT.
- `clear`, any state:
  - Zeroes the delay line, `acc` and `k`.
  - Sets `out_valid<=0`; any pending result is discarded.
  - Goes to IDLE.
  - A sample presented in the same cycle as `clear` is not accepted.
- Priority: `rst` > `clear` > handshake.
- Reset values: state IDLE, `in_ready=1` from the first cycle after reset, `out_valid=0`, `out_data=0`, delay line 0, `acc=0`, `k=0`.
- Reset or clear in the middle of MAC or OUT aborts the computation. No partial result is ever presented.

## Timing
- Acceptance edge A: `in_valid & in_ready` sampled high.
- MAC occupies the TAPS edges A+1..A+TAPS.
- `out_valid` rises after edge A+TAPS, giving a latency of TAPS cycles.
- The earliest `out_ready` handshake is at edge A+TAPS+1. `in_ready` is high again after that edge.
- Maximum throughput: one sample per TAPS+2 cycles, which is 6 at default parameters.
- `out_data` changes only on the MAC->OUT transition, or to 0 on reset. It is never changed by `clear`: clear drops `out_valid`, and the stale `out_data` value is don't-care.
- No combinational path from inputs to outputs. All outputs are registered or decoded from registered state.

## Test plan
- Default parameters, after reset, feed 1,2,3,4,0 with `out_ready=1` -> outputs 1, 4, 10, 20, 25. Each `out_valid` rises exactly 4 cycles after its acceptance edge.
- Feed 65535 five times -> fifth output is 655350. No truncation in the 26-bit `out_data`.
- After the first result, hold `out_ready=0` for 5 cycles with `in_valid=1` -> `out_data` and `out_valid` stay stable, `in_ready=0`, and no sample is taken. Release `out_ready` -> the next acceptance happens one cycle later.
- Feed 5,6, then assert `clear` during the second sample's MAC -> no result for 6, `out_valid=0`. Next sample 7 -> output 7, since history is zeroed.
- Assert `rst` while in OUT with a pending result -> `out_valid=0`, `in_ready=1` the next cycle. Sample 2 -> output 2.
- `TAPS=8`, `COEF_W=4`, all coefficients 15 (`COEFS=32'hFFFFFFFF`), `DATA_W=12`, feed 4095 eight times -> eighth output is 491400 (OUT_W=19). Latency is 8 cycles.

Source files
------------

// File: rtl/fir_stream_seq.sv
// fir_stream_seq: streaming FIR filter that evaluates all taps with one shared
// multiplier-accumulator, one tap per cycle, between valid/ready handshakes.
module fir_stream_seq #(
    parameter int DATA_W = 16,
    parameter int TAPS = 4,
    parameter int COEF_W = 8,
    parameter logic [TAPS*COEF_W-1:0] COEFS = {8'd4, 8'd3, 8'd2, 8'd1},
    parameter int OUT_W = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int KW = $clog2(TAPS);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] d [TAPS];
    logic [OUT_W-1:0] acc, prod;
    logic [KW-1:0] k;
    logic last;
    assign last = k == KW'(TAPS - 1);
    assign prod = OUT_W'(COEFS[k*COEF_W +: COEF_W]) * OUT_W'(d[k]);
    assign in_ready = state == IDLE;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        state_nx = clear ? IDLE
                 : (state == IDLE && in_valid) ? MAC
                 : (state == MAC && last) ? OUT
                 : (state == OUT && out_ready) ? IDLE
                 : state;
    end
    // out_data is only reset, never cleared; clear merely drops out_valid
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < TAPS; i++) d[i] <= '0;
            acc <= '0;
            k <= '0;
            out_valid <= 1'b0;
            if (rst) out_data <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    d[0] <= in_data;
                    for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
                    acc <= '0;
                    k <= '0;
                end
                MAC: begin
                    acc <= acc + prod;
                    k <= last ? '0 : k + KW'(1);
                    if (last) begin
                        out_data <= acc + prod;
                        out_valid <= 1'b1;
                    end
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
